// File: rtl/rx_ping_scheduler.sv
// rx_ping_scheduler
//   Sequences tone pings for the four RX sine generators. A ping is a burst of
//   burst_len samples with the tone enabled, followed by a gap that fills the
//   rest of a period_len-sample period. Phase offsets are staged at any time
//   and copied to the active outputs only while loading the next ping.
//
// Ports
//   clock, reset                  system clock, synchronous active-high reset
//   endata                        one-cycle sample strobe from the RX generators
//   start / stop / abort          begin / graceful stop / immediate stop pulses
//   burst_len, period_len         samples per burst and per full ping period
//   num_pings                     pings per sequence, 0 = unlimited
//   wr_en, wr_addr, wr_data       phase staging write port (addr 0..3 = ch 1..4)
//   enout                         tone enable for all four generators
//   phase1..phase4                active signed phase offsets
//   busy, done, cfg_err           status: not idle / sequence end / start rejected
//   ping_count                    pings completed in the current or last sequence
//
// state | meaning
// IDLE  | no sequence running
// LOAD  | copy staged phases, wait for the first sample of the next ping
// BURST | tone enabled, counting burst samples
// GAP   | tone disabled, counting the rest of the period
module rx_ping_scheduler #(
  parameter int PW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          endata,
  input  logic          start,
  input  logic          stop,
  input  logic          abort,
  input  logic [15:0]   burst_len,
  input  logic [15:0]   period_len,
  input  logic [15:0]   num_pings,
  input  logic          wr_en,
  input  logic [1:0]    wr_addr,
  input  logic [PW-1:0] wr_data,
  output logic          enout,
  output logic [PW-1:0] phase1,
  output logic [PW-1:0] phase2,
  output logic [PW-1:0] phase3,
  output logic [PW-1:0] phase4,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output logic [15:0]   ping_count
);

  typedef enum logic [1:0] {IDLE, LOAD, BURST, GAP} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] staging [4];
  logic [15:0]   burst_q, period_q, num_q;
  logic [15:0]   cnt, cnt_nx, ping_nx, ping_inc;
  logic          stop_flag, stop_nx, done_nx, cfg_err_nx;
  logic          latch_cfg, copy_phase, cfg_ok;

  assign cfg_ok   = (burst_len != 16'd0) && (period_len > burst_len);
  assign ping_inc = (ping_count == 16'hFFFF) ? ping_count : ping_count + 16'd1;

  assign enout = (state == BURST);
  assign busy  = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    ping_nx    = ping_count;
    stop_nx    = stop_flag;
    done_nx    = 1'b0;
    cfg_err_nx = 1'b0;
    latch_cfg  = 1'b0;
    copy_phase = 1'b0;
    if (abort) begin
      state_nx = IDLE;
      stop_nx  = 1'b0;
    end else begin
      // a stop seen while busy is remembered until the period ends
      if (state != IDLE && stop) stop_nx = 1'b1;
      case (state)
        IDLE: begin
          // start together with stop is treated as a cancelled request
          if (start && !stop) begin
            if (cfg_ok) begin
              state_nx  = LOAD;
              ping_nx   = 16'd0;
              cnt_nx    = 16'd0;
              latch_cfg = 1'b1;
            end else begin
              cfg_err_nx = 1'b1;
            end
          end
        end
        LOAD: begin
          copy_phase = 1'b1;
          cnt_nx     = 16'd0;
          if (endata) state_nx = BURST;
        end
        BURST: begin
          if (endata) begin
            cnt_nx = cnt + 16'd1;
            if (cnt == burst_q - 16'd1) state_nx = GAP;
          end
        end
        GAP: begin
          if (endata) begin
            cnt_nx = cnt + 16'd1;
            if (cnt == period_q - 16'd1) begin
              ping_nx = ping_inc;
              if (stop_nx || (num_q != 16'd0 && ping_inc == num_q)) begin
                state_nx = IDLE;
                done_nx  = 1'b1;
                stop_nx  = 1'b0;
              end else begin
                state_nx = LOAD;
              end
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      ping_count <= '0;
      stop_flag  <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      burst_q    <= '0;
      period_q   <= '0;
      num_q      <= '0;
      phase1     <= '0;
      phase2     <= '0;
      phase3     <= '0;
      phase4     <= '0;
      for (int i = 0; i < 4; i++) staging[i] <= '0;
    end else begin
      cnt        <= cnt_nx;
      ping_count <= ping_nx;
      stop_flag  <= stop_nx;
      done       <= done_nx;
      cfg_err    <= cfg_err_nx;
      if (latch_cfg) begin
        burst_q  <= burst_len;
        period_q <= period_len;
        num_q    <= num_pings;
      end
      if (copy_phase) begin
        phase1 <= staging[0];
        phase2 <= staging[1];
        phase3 <= staging[2];
        phase4 <= staging[3];
      end
      if (wr_en) staging[wr_addr] <= wr_data;
    end
  end

endmodule

// File: doc/rx_ping_scheduler.md
RX_PING_SCHEDULER -- requirements
Module: rx_ping_scheduler

Interface
REQ-001 Parameter: PW, 32, phase word width; must match the phase inputs of the RX sine generators.
REQ-002 clock  in  1  system clock.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 endata  in  1  one-cycle 100 kHz sample strobe from the RX generator block.
REQ-005 start  in  1  one-cycle pulse; begin a ping sequence.
REQ-006 stop  in  1  one-cycle pulse; graceful stop at end of current period.
REQ-007 abort  in  1  one-cycle pulse; immediate stop.
REQ-008 burst_len  in  16  samples per ping with tone enabled.
REQ-009 period_len  in  16  samples per ping period, burst plus gap.
REQ-010 num_pings  in  16  pings per sequence; 0 means unlimited.
REQ-011 wr_en  in  1  phase staging write strobe.
REQ-012 wr_addr  in  2  staging channel select, 0..3 maps to channel 1..4.
REQ-013 wr_data  in  PW  signed phase value.
REQ-014 enout  out  1  tone enable for all four RX generators.
REQ-015 phase1..phase4  out  PW each  active signed phase offsets.
REQ-016 busy  out  1  high when state is not IDLE.
REQ-017 done  out  1  one-cycle pulse when a sequence ends normally or by stop.
REQ-018 cfg_err  out  1  one-cycle pulse when start is rejected.
REQ-019 ping_count  out  16  pings completed in the current or last sequence.

Function
REQ-020 The block SHALL hold four staging phase registers; wr_en writes wr_data to staging[wr_addr] on any cycle and in any state.
REQ-021 phase1..4 SHALL update from staging only in LOAD, so that writes during BURST or GAP take effect at the next ping.
REQ-022 On an accepted start, burst_len, period_len and num_pings SHALL be latched; later input changes SHALL be ignored until the next start.
REQ-023 States SHALL be IDLE, LOAD, BURST and GAP, with a registered state.
REQ-024 IDLE: start with burst_len != 0 and period_len > burst_len SHALL go to LOAD next cycle and clear ping_count.
REQ-025 IDLE: start with invalid config SHALL stay in IDLE and pulse cfg_err for 1 cycle.
REQ-026 IDLE: if start and stop or abort occur on the same cycle, start SHALL be ignored and no cfg_err SHALL be raised.
REQ-027 LOAD: the block SHALL copy staging to phase outputs, clear the sample counter and wait for endata; on endata, go to BURST with the counter at 0.
REQ-028 The endata that causes LOAD->BURST SHALL not be counted.
REQ-029 enout SHALL equal (state == BURST) and change on the cycle after the state transition edge.
REQ-030 BURST: each endata SHALL increment the sample counter; endata with counter == burst_len-1 SHALL go to GAP, with the counter continuing.
REQ-031 GAP: endata with counter == period_len-1 SHALL increment ping_count (saturating at 0xFFFF) and end the period.
REQ-032 End of period: if the stop flag is set, or num_pings != 0 and the new ping_count == num_pings, go to IDLE and pulse done; otherwise go to LOAD.
REQ-033 stop while busy SHALL set a sticky flag, cleared on entering IDLE; the current burst and gap SHALL complete.
REQ-034 stop in IDLE SHALL have no effect.
REQ-035 abort in any state SHALL go to IDLE next cycle, with enout low from that edge; no done pulse and no ping_count increment.
REQ-036 phase1..4 SHALL retain their last values after abort.
REQ-037 Sample counter SHALL be 16 bits and never wrap within a valid period (period_len <= 0xFFFF).
REQ-038 endata outside LOAD, BURST and GAP SHALL be ignored.

Reset
REQ-039 reset SHALL take priority over all inputs and force state IDLE.
REQ-040 Reset values: enout=0, busy=0, done=0, cfg_err=0, ping_count=0, counter=0, stop flag=0, staging and phase1..4 = 0.
REQ-041 reset mid-burst SHALL drop enout on the same edge.

Verification
REQ-042 Staging write 0x00100000 to ch2, then start with burst=3, period=5, pings=2 -> enout high for exactly 3 endata periods, twice, with phase2=0x00100000; done pulses once; ping_count=2; busy low after.
REQ-043 start with burst=4, period=4 -> cfg_err 1-cycle pulse, busy stays 0, enout stays 0.
REQ-044 pings=0, stop during the 3rd burst -> the 3rd burst and gap complete, ping_count=3, done pulses, IDLE.
REQ-045 abort mid-burst -> enout low next cycle, no done pulse, ping_count unchanged.
REQ-046 Write ch1 phase during BURST of ping 1 -> phase1 unchanged until LOAD of ping 2, then new value.
REQ-047 start, stop and abort all asserted in IDLE -> stays IDLE, no cfg_err, no done.
